// File: rtl/ssr_pkg.sv
// ============================================================================
// Module      : ssr_pkg
// Description : Shared types and constants for the speech-recognition
//               sequencer: FSM state encoding, datapath widths, ADC midscale,
//               and a helper that returns a sample's distance from midscale.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ssr_pkg;

    localparam int ADC_W   = 12;
    localparam int CLASS_W = 2;

    localparam logic [ADC_W-1:0] ADC_MIDSCALE = 12'd2048;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CAPTURE   = 3'd1,
        FEAT_WAIT = 3'd2,
        NN_START  = 3'd3,
        NN_WAIT   = 3'd4,
        ERROR     = 3'd5
    } ssr_state_t;

    // |sample - midscale|; the largest result (2048 for sample 0) still fits
    // in ADC_W bits.
    function automatic logic [ADC_W-1:0] abs_dev(input logic [ADC_W-1:0] s);
        return (s >= ADC_MIDSCALE) ? (s - ADC_MIDSCALE) : (ADC_MIDSCALE - s);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ssr_btn_sync.sv
// ============================================================================
// Module      : ssr_btn_sync
// Description : Two-flop synchronizer for an asynchronous push button,
//               followed by a rising-edge detector. pulse_o is high for one
//               clk cycle per press.
// Ports       : clk     - system clock
//               rst     - asynchronous active-low reset
//               btn_i   - raw button level (asynchronous to clk)
//               pulse_o - one-cycle start pulse on a synchronized rising edge
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ssr_btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic pulse_o
);

    // [0],[1] form the synchronizer; [2] is the previous synchronized level.
    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], btn_i};
        end
    end

    assign pulse_o = sync_q[1] & ~sync_q[2];

endmodule

`default_nettype wire

// File: rtl/ssr_sequencer.sv
// ============================================================================
// Module      : ssr_sequencer
// Description : Top-level controller of the speech-recognition datapath.
//               A button press captures a SAMPLE_COUNT window of ADC samples
//               and forwards it to the feature extractor, then launches the
//               classifier and latches its 2-bit class. The feature and
//               classifier wait states are guarded by a watchdog.
// Macro       : SSR_ENERGY_TRIGGER_EN - when defined, IDLE also starts a
//               capture on the first sample whose |adc_data-2048| exceeds
//               ENERGY_THRESH; that sample is forwarded as sample 0.
// Ports       : clk, rst (async active-low), but (raw button),
//               adc_valid/adc_data (ADC stream),
//               ap_valid/ap_sample/ap_last (to feature extractor),
//               ap_done (feature vector ready), nn_start (start inference),
//               nn_done/nn_value (classifier result), result/result_valid
//               (latched class + update pulse), busy (not IDLE),
//               error (sticky timeout flag).
// Notes       : SAMPLE_COUNT and TIMEOUT_CYCLES must both be >= 2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ssr_sequencer
    import ssr_pkg::*;
#(
    parameter int SAMPLE_COUNT   = 16000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int ENERGY_THRESH  = 200
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               but,
    input  logic               adc_valid,
    input  logic [ADC_W-1:0]   adc_data,
    output logic               ap_valid,
    output logic [ADC_W-1:0]   ap_sample,
    output logic               ap_last,
    input  logic               ap_done,
    output logic               nn_start,
    input  logic               nn_done,
    input  logic [CLASS_W-1:0] nn_value,
    output logic [CLASS_W-1:0] result,
    output logic               result_valid,
    output logic               busy,
    output logic               error
);

    localparam int SCNT_W = $clog2(SAMPLE_COUNT);
    localparam int WD_W   = $clog2(TIMEOUT_CYCLES);

    localparam logic [SCNT_W-1:0] LAST_IDX = SCNT_W'(SAMPLE_COUNT - 1);
    localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

`ifdef SSR_ENERGY_TRIGGER_EN
    localparam bit ENERGY_EN = 1'b1;
`else
    localparam bit ENERGY_EN = 1'b0;
`endif

    ssr_state_t         state_q;
    logic [SCNT_W-1:0]  scnt_q;
    logic [WD_W-1:0]    wd_q;
    logic               ap_valid_q;
    logic [ADC_W-1:0]   ap_sample_q;
    logic               ap_last_q;
    logic               nn_start_q;
    logic [CLASS_W-1:0] result_q;
    logic               result_valid_q;
    logic               error_q;

    logic btn_start_d;
    logic energy_hit_d;
    logic energy_start_d;
    logic start_d;

    ssr_btn_sync u_btn_sync (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (but),
        .pulse_o (btn_start_d)
    );

    assign energy_hit_d   = 32'(abs_dev(adc_data)) > 32'(ENERGY_THRESH);
    assign energy_start_d = ENERGY_EN && adc_valid && energy_hit_d;
    // Button and energy trigger in the same cycle collapse into one start.
    assign start_d        = btn_start_d || energy_start_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            scnt_q         <= '0;
            wd_q           <= '0;
            ap_valid_q     <= 1'b0;
            ap_sample_q    <= '0;
            ap_last_q      <= 1'b0;
            nn_start_q     <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            ap_valid_q     <= 1'b0;
            ap_last_q      <= 1'b0;
            nn_start_q     <= 1'b0;
            result_valid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start_d) begin
                        state_q <= CAPTURE;
                        error_q <= 1'b0;
                        scnt_q  <= '0;
                        if (energy_start_d) begin
                            // The triggering sample is itself sample 0.
                            ap_valid_q  <= 1'b1;
                            ap_sample_q <= adc_data;
                            scnt_q      <= SCNT_W'(1);
                        end
                    end
                end

                CAPTURE: begin
                    if (adc_valid) begin
                        ap_valid_q  <= 1'b1;
                        ap_sample_q <= adc_data;
                        if (scnt_q == LAST_IDX) begin
                            ap_last_q <= 1'b1;
                            state_q   <= FEAT_WAIT;
                            wd_q      <= '0;
                        end else begin
                            scnt_q <= scnt_q + 1'b1;
                        end
                    end
                end

                FEAT_WAIT: begin
                    // Done is tested first so it wins a tie with expiry.
                    if (ap_done) begin
                        state_q    <= NN_START;
                        nn_start_q <= 1'b1;
                    end else if (wd_q == WD_LAST) begin
                        state_q <= ERROR;
                        error_q <= 1'b1;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end

                NN_START: begin
                    state_q <= NN_WAIT;
                    wd_q    <= '0;
                end

                NN_WAIT: begin
                    if (nn_done) begin
                        state_q        <= IDLE;
                        result_q       <= nn_value;
                        result_valid_q <= 1'b1;
                    end else if (wd_q == WD_LAST) begin
                        state_q <= ERROR;
                        error_q <= 1'b1;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end

                ERROR: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ap_valid     = ap_valid_q;
    assign ap_sample    = ap_sample_q;
    assign ap_last      = ap_last_q;
    assign nn_start     = nn_start_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign error        = error_q;
    assign busy         = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ssr_sequencer.sv
// ============================================================================
// Module      : tb_ssr_sequencer
// Description : Self-checking bench for ssr_sequencer with SAMPLE_COUNT=8 and
//               TIMEOUT_CYCLES=20. A table of whole transactions with their
//               expected outcome, randomized transactions scored against a
//               behavioural model, and hand-written corner-case sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ssr_sequencer;

    localparam int SC = 8;
    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        but = 1'b0;
    logic        adc_valid = 1'b0;
    logic [11:0] adc_data = 12'd0;
    logic        ap_valid;
    logic [11:0] ap_sample;
    logic        ap_last;
    logic        ap_done = 1'b0;
    logic        nn_start;
    logic        nn_done = 1'b0;
    logic [1:0]  nn_value = 2'd0;
    logic [1:0]  result;
    logic        result_valid;
    logic        busy;
    logic        error;

    ssr_sequencer #(
        .SAMPLE_COUNT   (SC),
        .TIMEOUT_CYCLES (TO),
        .ENERGY_THRESH  (200)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .but          (but),
        .adc_valid    (adc_valid),
        .adc_data     (adc_data),
        .ap_valid     (ap_valid),
        .ap_sample    (ap_sample),
        .ap_last      (ap_last),
        .ap_done      (ap_done),
        .nn_start     (nn_start),
        .nn_done      (nn_done),
        .nn_value     (nn_value),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .error        (error)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Scoreboard fed by a monitor sampling on the falling edge.
    logic [12:0] obs[$];
    int          ns_cnt = 0;
    int          rv_cnt = 0;

    always @(negedge clk) begin
        if (ap_valid) obs.push_back({ap_last, ap_sample});
        if (nn_start) ns_cnt++;
        if (result_valid) rv_cnt++;
    end

    // Behavioural model state: latched class and sticky error.
    logic [1:0]  model_res = 2'd0;
    logic        model_err = 1'b0;
    logic [11:0] smp[SC];

    typedef struct {
        logic [11:0] base;
        int          kf;       // ap_done sampled kf edges after FEAT_WAIT entry
        int          mn;       // nn_done sampled mn edges after nn_start edge
        logic [1:0]  val;
        logic [1:0]  exp_res;
        logic        exp_err;
        int          exp_ns;
        logic        mid;      // press the button again during capture
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press();
        int n = 0;
        but = 1'b1;
        while (!busy && n < 10) begin
            tick();
            n++;
        end
        chk("start_accepted", 32'(busy), 32'd1);
        but = 1'b0;
    endtask

    task automatic capture(input int cnt, input logic mid);
        for (int i = 0; i < cnt; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            if (mid && i == 4) begin
                but = 1'b1;
                repeat (3) tick();
                but = 1'b0;
            end
            adc_valid = 1'b1;
            adc_data  = smp[i];
            tick();
            adc_valid = 1'b0;
            adc_data  = 12'($urandom);
        end
    endtask

    task automatic run_txn(input string tag, input int kf, input int mn, input logic [1:0] val,
                           input logic [1:0] exp_res, input logic exp_err, input int exp_ns,
                           input logic mid);
        int n;
        obs.delete();
        ns_cnt = 0;
        rv_cnt = 0;
        press();
        chk({tag, "_err_cleared"}, 32'(error), 32'd0);
        capture(SC, mid);
        repeat (kf - 1) tick();
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        if (kf <= TO) begin
            repeat (mn - 1) tick();
            nn_done  = 1'b1;
            nn_value = val;
            tick();
            nn_done  = 1'b0;
            nn_value = 2'($urandom);
        end
        n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        tick();
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_nsamples"}, 32'(obs.size()), SC);
        for (int i = 0; i < SC; i++) begin
            logic [12:0] got;
            got = (i < obs.size()) ? obs[i] : 13'h1FFF;
            chk($sformatf("%s_sample%0d", tag, i), 32'(got), 32'({(i == SC - 1), smp[i]}));
        end
        chk({tag, "_nn_start_cnt"}, ns_cnt, exp_ns);
        chk({tag, "_result_valid_cnt"}, rv_cnt, exp_err ? 0 : 1);
        chk({tag, "_result"}, 32'(result), 32'(exp_res));
        chk({tag, "_error"}, 32'(error), 32'(exp_err));
    endtask

    initial begin
        int n;
        int kf;
        int mn;
        logic [1:0] v;
        logic ok;

        tbl[0] = '{12'h100, 5,  3,  2'b10, 2'b10, 1'b0, 1, 1'b0};
        tbl[1] = '{12'hFF8, 1,  2,  2'b01, 2'b01, 1'b0, 1, 1'b1};
        tbl[2] = '{12'h000, 20, 5,  2'b00, 2'b00, 1'b0, 1, 1'b0};
        tbl[3] = '{12'h800, 3,  21, 2'b11, 2'b11, 1'b0, 1, 1'b0};
        tbl[4] = '{12'h555, 21, 2,  2'b01, 2'b11, 1'b1, 0, 1'b0};
        tbl[5] = '{12'hAAA, 4,  22, 2'b10, 2'b11, 1'b1, 1, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({ap_valid, ap_sample, ap_last, nn_start, result,
                                  result_valid, busy, error}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) tick();

        // Table-driven transactions
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < SC; i++) smp[i] = 12'(tbl[t].base + 12'(i));
            run_txn($sformatf("tbl%0d", t), tbl[t].kf, tbl[t].mn, tbl[t].val,
                    tbl[t].exp_res, tbl[t].exp_err, tbl[t].exp_ns, tbl[t].mid);
        end
        model_res = 2'b11;
        model_err = 1'b1;

        // Randomized transactions against the model
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < SC; i++) smp[i] = 12'($urandom);
            kf = $urandom_range(1, 23);
            mn = $urandom_range(2, 24);
            v  = 2'($urandom);
            ok = (kf <= TO) && (mn <= TO + 1);
            if (ok) model_res = v;
            model_err = !ok;
            run_txn($sformatf("rnd%0d", t), kf, mn, v, model_res, model_err,
                    (kf <= TO) ? 1 : 0, 1'b0);
        end

        // Exact feature-wait timeout: error rises TO edges after entry
        for (int i = 0; i < SC; i++) smp[i] = 12'(12'h200 + 12'(i));
        press();
        capture(SC, 1'b0);
        n = 0;
        while (!error && n < 40) begin
            tick();
            n++;
        end
        chk("timeout_cycles", n, TO);
        tick();
        chk("timeout_back_idle", 32'(busy), 32'd0);
        chk("timeout_result_kept", 32'(result), 32'(model_res));
        model_err = 1'b1;

        // Stray done pulses and samples while IDLE
        obs.delete();
        ns_cnt = 0;
        rv_cnt = 0;
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        nn_done = 1'b1;
        nn_value = ~model_res;
        tick();
        nn_done = 1'b0;
        adc_data = 12'd2048;
        adc_valid = 1'b1;
        repeat (3) tick();
        adc_valid = 1'b0;
        repeat (3) tick();
        chk("stray_busy", 32'(busy), 32'd0);
        chk("stray_no_samples", 32'(obs.size()), 32'd0);
        chk("stray_result", 32'(result), 32'(model_res));
        chk("stray_no_pulses", ns_cnt + rv_cnt, 0);
        chk("stray_error_kept", 32'(error), 32'(model_err));

        // Reset mid-capture, then a fresh full window
        for (int i = 0; i < SC; i++) smp[i] = 12'(12'h3C0 + 12'(i));
        press();
        capture(4, 1'b0);
        rst = 1'b0;
        #2;
        chk("midreset_outputs", 32'({ap_valid, ap_sample, ap_last, nn_start, result,
                                     result_valid, busy, error}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        model_res = 2'b01;
        model_err = 1'b0;
        run_txn("after_reset", 5, 3, 2'b01, model_res, model_err, 1, 1'b0);

`ifdef SSR_ENERGY_TRIGGER_EN
        // Energy trigger: 2100 is below threshold, 2300 starts capture
        obs.delete();
        adc_valid = 1'b1;
        adc_data  = 12'd2100;
        tick();
        adc_valid = 1'b0;
        chk("en_below_idle", 32'(busy), 32'd0);
        adc_valid = 1'b1;
        adc_data  = 12'd2300;
        tick();
        adc_valid = 1'b0;
        chk("en_trig_busy", 32'(busy), 32'd1);
        chk("en_trig_sample0", 32'({ap_valid, ap_sample}), 32'({1'b1, 12'd2300}));
        for (int i = 1; i < SC; i++) begin
            adc_valid = 1'b1;
            adc_data  = 12'(12'h300 + 12'(i));
            tick();
            adc_valid = 1'b0;
        end
        chk("en_nsamples", 32'(obs.size()), SC);
        chk("en_last", 32'((obs.size() == SC) ? obs[SC-1] : 13'h0),
            32'({1'b1, 12'(12'h300 + 12'(SC - 1))}));
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        tick();
        nn_done  = 1'b1;
        nn_value = 2'b10;
        tick();
        nn_done = 1'b0;
        tick();
        chk("en_result", 32'({busy, result}), 32'({1'b0, 2'b10}));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends on its own.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
